fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that consumes the next-PC decision made by the PC-select logic and turns it into instruction-memory requests. Holds the architectural fetch PC, issues one outstanding request at a time on the instruction bus, buffers the returned instruction, and presents it to decode with a valid/ready handshake. Redirects (taken branch, JAL/JALR) arrive from the execute-side PC selector. Wrong-path requests already on the bus are drained and their responses discarded.

## Interface
- RESET_PC, 64'h8000_0000, fetch PC loaded on reset

- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- redirect_valid  in  1  one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  in  64  target from PC selector; bits [1:0] ignored (treated as 0)
- ireq_valid  out  1  instruction request valid
- ireq_addr  out  64  request address, 4-byte aligned
- ireq_addr_ok  in  1  memory accepts request this cycle
- iresp_data_ok  in  1  response data valid this cycle
- iresp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts this cycle
- if_pc  out  64  PC of presented instruction
- if_instr  out  32  presented instruction

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Registers: pc (64), buf_instr (32), pend (1), pend_pc (64).
- IDLE: entered on reset. Next cycle goes to REQ unconditionally. iresp_data_ok ignored.
- REQ: ireq_valid=1, ireq_addr=pc. Address held stable until ireq_addr_ok.
  - addr_ok, no redirect this cycle, pend=0 -> WAIT.
  - addr_ok with redirect this cycle, or pend=1 -> DRAIN. The redirect target is saved in pend_pc.
  - Redirect without addr_ok: set pend=1 and pend_pc=redirect_pc. Stay in REQ with the old address.
- WAIT: waits for iresp_data_ok.
  - data_ok, no redirect -> buf_instr<=iresp_data, go to HOLD.
  - data_ok with redirect -> drop the data, pc<=redirect_pc, go to REQ.
  - Redirect without data_ok -> pend_pc<=redirect_pc, go to DRAIN.
- HOLD: if_valid=1, if_pc=pc, if_instr=buf_instr.
  - if_ready, no redirect -> pc<=pc+4, go to REQ.
  - Redirect, with or without if_ready -> drop the buffer, pc<=redirect_pc, go to REQ. Redirect wins over if_ready.
- DRAIN: waits for the wrong-path data_ok. On data_ok: discard it, pc<=pend_pc, pend<=0, go to REQ.
  - A newer redirect while in DRAIN overwrites pend_pc. Last redirect wins.
- Arithmetic: pc+4 is modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Only one request is ever outstanding. ireq_valid is never asserted in WAIT, HOLD or DRAIN.

## Timing
- Reset values: ireq_valid=0, ireq_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=0, pend=0, state=IDLE.
- Asynchronous reset mid-operation: all state returns to reset values immediately. Any response still in flight is ignored in IDLE.
- First request: ireq_valid rises 1 cycle after reset deasserts (cycle 1 is IDLE, cycle 2 is REQ).
- Best-case latency: addr_ok in cycle N, data_ok in N+1, if_valid in N+2. Minimum time from REQ entry to if_valid is 2 cycles.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with if_ready). There is no bypass from the response to if_valid.
- Redirect in HOLD: if_valid drops in the next cycle, and ireq_valid with the new address is asserted in that same cycle.
- All outputs are registered or decoded from state. There is no combinational path from any input to ireq_valid or if_valid.

## Test plan
- Reset release with RESET_PC=0x8000_0000; memory gives addr_ok immediately and data_ok 1 cycle later -> ireq_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. if_pc/if_instr match the returned words, one instruction every 3 cycles with if_ready=1.
- Hold if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr stay stable and no new request is issued. Releasing ready advances to pc+4.
- Redirect to 0x8000_0100 while in WAIT, with data_ok 3 cycles later -> that data is never presented. The next ireq_addr is 0x8000_0100.
- Redirect in REQ with addr_ok withheld 4 cycles -> ireq_addr stays at the old address until accepted. After the discarded response, fetch restarts at redirect_pc.
- Redirect with redirect_pc=0x8000_0203 in the same cycle as if_ready in HOLD -> the instruction is not counted as advancing, and the next ireq_addr is 0x8000_0200.
- Assert reset while in DRAIN, then release -> ireq_valid rises again at RESET_PC. The stray data_ok arriving in IDLE is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch front end; one outstanding I-bus request,
//             single-entry instruction buffer, redirect with wrong-path drain.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [63:0] c_pc_step    = 64'd4;
  localparam logic [63:0] c_align_mask = ~64'd3;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_pend_pc;
  logic [31:0] r_buf_instr;
  logic        r_pend;
  logic        r_ireq_valid;
  logic        r_if_valid;

  logic [63:0] w_redirect_tgt;

  assign w_redirect_tgt = redirect_pc & c_align_mask;

  // Valid flags are registered alongside the state so no input reaches them
  // combinationally; address and PC outputs come straight from r_pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_pend_pc    <= RESET_PC;
      r_buf_instr  <= 32'd0;
      r_pend       <= 1'b0;
      r_ireq_valid <= 1'b0;
      r_if_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state      <= S_REQ;
          r_ireq_valid <= 1'b1;
        end

        S_REQ: begin
          if (ireq_addr_ok) begin
            r_ireq_valid <= 1'b0;
            if (redirect_valid || r_pend) begin
              // Request already on the bus is wrong-path: drain it first.
              r_state <= S_DRAIN;
              r_pend  <= 1'b1;
              if (redirect_valid) begin
                r_pend_pc <= w_redirect_tgt;
              end
            end else begin
              r_state <= S_WAIT;
            end
          end else if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= w_redirect_tgt;
          end
        end

        S_WAIT: begin
          if (iresp_data_ok) begin
            if (redirect_valid) begin
              r_pc         <= w_redirect_tgt;
              r_state      <= S_REQ;
              r_ireq_valid <= 1'b1;
            end else begin
              r_buf_instr <= iresp_data;
              r_state     <= S_HOLD;
              r_if_valid  <= 1'b1;
            end
          end else if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= w_redirect_tgt;
            r_state   <= S_DRAIN;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            r_pc         <= w_redirect_tgt;
            r_state      <= S_REQ;
            r_if_valid   <= 1'b0;
            r_ireq_valid <= 1'b1;
          end else if (if_ready) begin
            r_pc         <= r_pc + c_pc_step;
            r_state      <= S_REQ;
            r_if_valid   <= 1'b0;
            r_ireq_valid <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (iresp_data_ok) begin
            // A redirect landing with the drained response is the newest target.
            r_pc         <= redirect_valid ? w_redirect_tgt : r_pend_pc;
            r_pend       <= 1'b0;
            r_state      <= S_REQ;
            r_ireq_valid <= 1'b1;
          end else if (redirect_valid) begin
            r_pend_pc <= w_redirect_tgt;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_ireq_valid <= 1'b0;
          r_if_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign ireq_valid = r_ireq_valid;
  assign ireq_addr  = r_pc;
  assign if_valid   = r_if_valid;
  assign if_pc      = r_pc;
  assign if_instr   = r_buf_instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed vector table,
//             reset/wrap sequences and randomized traffic vs. a stream model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [63:0] c_reset_pc = 64'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(c_reset_pc)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_addr_ok  (ireq_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        e_iv;
    logic [63:0] e_ia;
    logic        e_fv;
    logic [63:0] e_fpc;
    logic [31:0] e_fi;
  } vec_t;

  vec_t vt[30];

  function automatic vec_t mk(input logic aok, input logic dok, input logic [31:0] data,
                              input logic rdy, input logic rv, input logic [63:0] rpc,
                              input logic e_iv, input logic [63:0] e_ia, input logic e_fv,
                              input logic [63:0] e_fpc, input logic [31:0] e_fi);
    vec_t v;
    v.aok = aok; v.dok = dok; v.data = data; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_iv = e_iv; v.e_ia = e_ia; v.e_fv = e_fv; v.e_fpc = e_fpc; v.e_fi = e_fi;
    return v;
  endfunction

  // Memory image used by the random phase: the word at an address is a fixed hash of it.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    ireq_addr_ok   = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'd0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
  endtask

  localparam logic [63:0] A  = 64'h8000_0000;
  localparam logic [31:0] D0 = 32'h0000_0093, D1 = 32'h0010_0113, D2 = 32'h0020_0193;
  localparam logic [31:0] D3 = 32'h0030_0213, D4 = 32'hCAFE_0013, D5 = 32'h1234_5678;
  localparam logic [31:0] D6 = 32'h0BAD_F00D, BAD = 32'hDEAD_BEEF;

  // Random-phase model state
  logic [63:0] exp_pc;
  logic        resp_pend;
  logic [63:0] resp_addr;
  logic        prev_wait;
  logic [63:0] prev_addr;
  logic [63:0] tgt;
  int          handshakes;

  initial begin
    rst_n = 1'b0;
    drive_idle();

    // Directed cycle table: outputs expected at each step, then that step's inputs.
    vt[0]  = mk(0,0,0,  0,0,0,             0,A,     0,0,0);
    vt[1]  = mk(1,0,0,  0,0,0,             1,A,     0,0,0);
    vt[2]  = mk(0,1,D0, 0,0,0,             0,0,     0,0,0);
    vt[3]  = mk(0,0,0,  1,0,0,             0,0,     1,A,D0);
    vt[4]  = mk(1,0,0,  0,0,0,             1,A+4,   0,0,0);
    vt[5]  = mk(0,1,D1, 0,0,0,             0,0,     0,0,0);
    for (int i = 6; i <= 10; i++)
      vt[i] = mk(0,0,0, 0,0,0,             0,0,     1,A+4,D1);
    vt[11] = mk(0,0,0,  1,0,0,             0,0,     1,A+4,D1);
    vt[12] = mk(1,0,0,  0,0,0,             1,A+8,   0,0,0);
    vt[13] = mk(0,0,0,  0,1,A+64'h100,     0,0,     0,0,0);
    vt[14] = mk(0,0,0,  0,0,0,             0,0,     0,0,0);
    vt[15] = mk(0,0,0,  0,0,0,             0,0,     0,0,0);
    vt[16] = mk(0,1,BAD,0,0,0,             0,0,     0,0,0);
    vt[17] = mk(0,0,0,  0,1,A+64'h203,     1,A+64'h100, 0,0,0);
    for (int i = 18; i <= 20; i++)
      vt[i] = mk(0,0,0, 0,0,0,             1,A+64'h100, 0,0,0);
    vt[21] = mk(1,0,0,  0,0,0,             1,A+64'h100, 0,0,0);
    vt[22] = mk(0,1,BAD,0,0,0,             0,0,     0,0,0);
    vt[23] = mk(1,0,0,  0,0,0,             1,A+64'h200, 0,0,0);
    vt[24] = mk(0,1,D2, 0,0,0,             0,0,     0,0,0);
    vt[25] = mk(0,0,0,  1,1,A+64'h203,     0,0,     1,A+64'h200,D2);
    vt[26] = mk(1,0,0,  0,0,0,             1,A+64'h200, 0,0,0);
    vt[27] = mk(0,1,D3, 0,0,0,             0,0,     0,0,0);
    vt[28] = mk(0,0,0,  1,0,0,             0,0,     1,A+64'h200,D3);
    vt[29] = mk(1,0,0,  0,0,0,             1,A+64'h204, 0,0,0);

    repeat (2) @(negedge clk);
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_ireq_addr",  ireq_addr,  c_reset_pc);
    chk("rst_if_valid",   if_valid,   0);
    chk("rst_if_pc",      if_pc,      c_reset_pc);
    chk("rst_if_instr",   if_instr,   0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      chk($sformatf("vec%0d_ireq_valid", i), ireq_valid, vt[i].e_iv);
      if (vt[i].e_iv) chk($sformatf("vec%0d_ireq_addr", i), ireq_addr, vt[i].e_ia);
      chk($sformatf("vec%0d_if_valid", i), if_valid, vt[i].e_fv);
      if (vt[i].e_fv) begin
        chk($sformatf("vec%0d_if_pc", i), if_pc, vt[i].e_fpc);
        chk($sformatf("vec%0d_if_instr", i), if_instr, vt[i].e_fi);
      end
      ireq_addr_ok   = vt[i].aok;
      iresp_data_ok  = vt[i].dok;
      iresp_data     = vt[i].data;
      if_ready       = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      @(negedge clk);
    end

    // Redirect in WAIT -> DRAIN, then asynchronous reset mid-cycle.
    drive_idle();
    redirect_valid = 1'b1; redirect_pc = A + 64'h400;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    chk("drain_ireq_valid", ireq_valid, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ireq_valid", ireq_valid, 0);
    chk("async_rst_ireq_addr",  ireq_addr,  c_reset_pc);
    chk("async_rst_if_valid",   if_valid,   0);
    chk("async_rst_if_instr",   if_instr,   0);
    @(negedge clk);
    rst_n = 1'b1;
    iresp_data_ok = 1'b1; iresp_data = BAD;   // stray response lands in IDLE
    @(negedge clk);
    drive_idle();
    chk("restart_ireq_valid", ireq_valid, 1);
    chk("restart_ireq_addr",  ireq_addr,  c_reset_pc);
    ireq_addr_ok = 1'b1;
    @(negedge clk);
    drive_idle();
    iresp_data_ok = 1'b1; iresp_data = D4;
    @(negedge clk);
    drive_idle();
    chk("restart_if_valid", if_valid, 1);
    chk("restart_if_pc",    if_pc,    c_reset_pc);
    chk("restart_if_instr", if_instr, D4);

    // Wrap-around of the fetch PC at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFD;
    @(negedge clk);
    drive_idle();
    chk("wrap_hold_drop", if_valid, 0);
    chk("wrap_req_valid", ireq_valid, 1);
    chk("wrap_req_addr",  ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    ireq_addr_ok = 1'b1;
    @(negedge clk);
    drive_idle();
    iresp_data_ok = 1'b1; iresp_data = D5;
    @(negedge clk);
    drive_idle();
    chk("wrap_if_pc",    if_pc,    64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_if_instr", if_instr, D5);
    if_ready = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("wrap_next_valid", ireq_valid, 1);
    chk("wrap_next_addr",  ireq_addr,  64'd0);
    ireq_addr_ok = 1'b1;
    @(negedge clk);
    drive_idle();
    iresp_data_ok = 1'b1; iresp_data = D6;
    @(negedge clk);
    drive_idle();
    chk("wrap_zero_pc",    if_pc,    64'd0);
    chk("wrap_zero_instr", if_instr, D6);

    // Randomized traffic: the model tracks only the architectural instruction stream.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    exp_pc     = c_reset_pc;
    resp_pend  = 1'b0;
    resp_addr  = 64'd0;
    prev_wait  = 1'b0;
    prev_addr  = 64'd0;
    handshakes = 0;
    for (int k = 0; k < 3000; k++) begin
      chk("rnd_exclusive", ireq_valid & if_valid, 0);
      if (if_valid) begin
        chk("rnd_if_pc",    if_pc,    exp_pc);
        chk("rnd_if_instr", if_instr, mem_word(exp_pc));
      end
      if (ireq_valid) begin
        chk("rnd_one_outstanding", resp_pend, 0);
        chk("rnd_align", ireq_addr[1:0], 0);
        if (prev_wait) chk("rnd_addr_stable", ireq_addr, prev_addr);
      end

      drive_idle();
      if (resp_pend && ($urandom_range(0, 9) < 6)) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem_word(resp_addr);
        resp_pend     = 1'b0;
      end else begin
        iresp_data = $urandom;
      end
      ireq_addr_ok = ireq_valid && ($urandom_range(0, 9) < 7);
      if (ireq_addr_ok) begin
        resp_pend = 1'b1;
        resp_addr = ireq_addr;
      end
      if_ready = ($urandom_range(0, 3) != 0);
      if (k >= 2 && $urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0)
          redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        else
          redirect_pc = c_reset_pc + 64'($urandom_range(0, 1023));
      end

      if (redirect_valid) begin
        tgt    = redirect_pc;
        exp_pc = {tgt[63:2], 2'b00};
      end else if (if_valid && if_ready) begin
        handshakes++;
        exp_pc = exp_pc + 64'd4;
      end
      prev_wait = ireq_valid && !ireq_addr_ok;
      prev_addr = ireq_addr;
      @(negedge clk);
    end
    drive_idle();
    chk("rnd_progress", (handshakes >= 100) ? 64'd1 : 64'd0, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
